// File: rtl/fc_in_buffer.sv
// fc_in_buffer: serial-to-parallel activation collector for an FC layer.
// Words arrive over a valid/ready stream and are assembled into the flat
// vector x (entry i at x[i*WIDTH +: WIDTH]). The finished vector is held
// stable and released through the x_valid/x_ready handshake.
//
// Optional feature macro: FC_IN_PINGPONG_EN
//   undefined - one bank; filling stalls while a vector is held.
//   defined   - two banks; the next vector fills while the previous is held.
module fc_in_buffer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [IN*WIDTH-1:0]   x,
    output logic                  x_valid,
    input  logic                  x_ready,
    output logic                  err
);

    localparam int PW = (IN > 1) ? $clog2(IN) : 1;

`ifdef FC_IN_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [PW-1:0]          r_wptr;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_last_idx;
    logic                   w_done;
    logic                   w_xfer;
    logic [NB-1:0]          w_wsel;
    logic [IN*WIDTH-1:0]    w_bank_x [0:NB-1];

    assign w_accept   = s_valid & s_ready;
    assign w_last_idx = (r_wptr == PW'(IN - 1));
    // A vector completes on an explicit last or when the final slot is filled.
    assign w_done     = w_accept & (s_last | w_last_idx);
    assign w_xfer     = x_valid & x_ready;
    assign err        = r_err;

    // Write pointer: advances per accepted word, wraps to 0 on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_done) begin
            r_wptr <= '0;
        end else if (w_accept) begin
            r_wptr <= r_wptr + PW'(1);
        end
    end

    // Framing error: last flag and last slot must coincide; pulse one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & (s_last ^ w_last_idx);
        end
    end

    // Vector storage. Entries are plain registers because the layer reads
    // every entry in parallel each cycle.
    generate
        for (genvar bi = 0; bi < NB; bi++) begin : g_bank
            for (genvar gi = 0; gi < IN; gi++) begin : g_ent
                logic [WIDTH-1:0] r_entry;

                // Write the addressed entry; an early last zeroes the tail.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_entry <= '0;
                    end else if (w_wsel[bi]) begin
                        if (w_accept && (r_wptr == PW'(gi))) begin
                            r_entry <= s_data;
                        end else if (w_done && s_last && (r_wptr < PW'(gi))) begin
                            r_entry <= '0;
                        end
                    end
                end

                assign w_bank_x[bi][gi*WIDTH +: WIDTH] = r_entry;
            end
        end
    endgenerate

`ifdef FC_IN_PINGPONG_EN
    logic       r_wb;
    logic       r_rb;
    logic [1:0] r_count;

    assign w_wsel  = {r_wb, ~r_wb};
    assign s_ready = ~rst & (r_count != 2'd2);
    assign x_valid = (r_count != 2'd0);
    assign x       = w_bank_x[r_rb];

    // Bank bookkeeping: completion fills bank wb, a transfer frees bank rb.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb    <= 1'b0;
            r_rb    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_done) begin
                r_wb <= ~r_wb;
            end
            if (w_xfer) begin
                r_rb <= ~r_rb;
            end
            case ({w_done, w_xfer})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0] r_state;

    assign w_wsel  = 1'b1;
    assign s_ready = ~rst & (r_state == ST_FILL);
    assign x_valid = (r_state == ST_HOLD);
    assign x       = w_bank_x[0];

    // FILL accepts words until completion; HOLD waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            case (r_state)
                ST_FILL: if (w_done) r_state <= ST_HOLD;
                ST_HOLD: if (w_xfer) r_state <= ST_FILL;
                default: r_state <= ST_FILL;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_fc_in_buffer.sv
// Self-checking bench for fc_in_buffer: directed sequences plus a small
// vector table for the early-last case. Works with and without
// FC_IN_PINGPONG_EN (expected s_ready during hold follows the build).
module tb_fc_in_buffer;

    localparam int WIDTH = 8;
    localparam int IN    = 128;
`ifdef FC_IN_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [WIDTH-1:0]    s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [IN*WIDTH-1:0] x;
    logic                x_valid;
    logic                x_ready;
    logic                err;

    fc_in_buffer #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             l;
        logic             xr;
        logic             e_rdy;
        logic             e_xv;
        logic             e_err;
        int               idx;
        logic [WIDTH-1:0] e_x;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] xe(input int i);
        return x[i*WIDTH +: WIDTH];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cyc;
        int errs;
        int mism;
        logic acc;
        logic [IN*WIDTH-1:0] snap;

        // Early-last table: 5 x 0xFF, last on the 5th, then release.
        tbl[0] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        tbl[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        tbl[2] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        tbl[3] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        tbl[4] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, PP,   1'b1, 1'b1,  4, 8'hFF};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, PP,   1'b1, 1'b0,  5, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, PP,   1'b1, 1'b0,  0, 8'hFF};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, PP,   1'b1, 1'b0, 127, 8'h00};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8'h00};

        // Reset
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; x_ready = 1'b0;
        tick; tick;
        chk("rst_s_ready_low", s_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_x_valid", x_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_x_zero", (x == '0), 1'b1);
        $display("reset done");
        tick;

        // Basic fill: words 1..128, last on the 128th
        for (int i = 0; i < IN; i++) begin
            s_valid = 1'b1; s_data = WIDTH'(i + 1); s_last = (i == IN - 1);
            chk("fill_s_ready", s_ready, 1'b1);
            tick;
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("fill_x_valid", x_valid, 1'b1);
        chk("fill_s_ready_hold", s_ready, PP);
        chk("fill_err", err, 1'b0);
        mism = 0;
        for (int i = 0; i < IN; i++) if (xe(i) !== WIDTH'(i + 1)) mism++;
        chk("fill_x_contents_mismatches", mism, 0);
        snap = x;
        for (int c = 0; c < 10; c++) tick;
        chk("fill_x_stable", (x == snap), 1'b1);
        chk("fill_x_valid_held", x_valid, 1'b1);
        $display("basic fill: 128 words");

        // Release
        x_ready = 1'b1;
        tick;
        x_ready = 1'b0;
        chk("rel_x_valid", x_valid, 1'b0);
        chk("rel_s_ready", s_ready, 1'b1);
        $display("release done");

        // Early last via table
        for (int r = 0; r < 10; r++) begin
            s_valid = tbl[r].v; s_data = tbl[r].d; s_last = tbl[r].l; x_ready = tbl[r].xr;
            chk($sformatf("el%0d_s_ready", r), s_ready, tbl[r].e_rdy);
            chk($sformatf("el%0d_x_valid", r), x_valid, tbl[r].e_xv);
            chk($sformatf("el%0d_err", r), err, tbl[r].e_err);
            if (tbl[r].idx >= 0)
                chk($sformatf("el%0d_x%0d", r, tbl[r].idx), xe(tbl[r].idx), tbl[r].e_x);
            $display("early-last row %0d: v=%0b d=%0h l=%0b xr=%0b", r, tbl[r].v, tbl[r].d, tbl[r].l, tbl[r].xr);
            tick;
        end

        // Missing last: 130 words, no s_last, x_ready tied high
        n = 0; cyc = 0; errs = 0;
        x_ready = 1'b1;
        while (n < 130 && cyc < 1000) begin
            s_valid = 1'b1; s_last = 1'b0; s_data = WIDTH'(8'h10 + n);
            if (err) begin
                errs++;
                chk("ml_err_after_word", n, 128);
                chk("ml_x_valid", x_valid, 1'b1);
                chk("ml_x127", xe(127), WIDTH'(8'h10 + 127));
                chk("ml_x0", xe(0), 8'h10);
            end
            acc = s_ready;
            tick;
            if (acc) n++;
            cyc++;
        end
        s_valid = 1'b0; x_ready = 1'b0;
        if (err) errs++;
        chk("ml_words", n, 130);
        chk("ml_err_pulses", errs, 1);
        chk("ml_next_x0", xe(0), WIDTH'(8'h10 + 128));
        chk("ml_next_x1", xe(1), WIDTH'(8'h10 + 129));
        chk("ml_next_x_valid", x_valid, 1'b0);
        $display("missing last: %0d words, %0d err pulses", n, errs);

        // Backpressure then reset after 60 words
        n = 0; cyc = 0;
        while (n < 60 && cyc < 2000) begin
            s_valid = 1'($urandom_range(0, 1)); s_data = 8'hA0; s_last = 1'b0;
            acc = s_valid && s_ready;
            tick;
            if (acc) n++;
            cyc++;
        end
        chk("bp_words", n, 60);
        s_valid = 1'b0; rst = 1'b1;
        #1;
        chk("bp_s_ready_in_rst", s_ready, 1'b0);
        tick;
        rst = 1'b0;
        #1;
        chk("bp_x_valid", x_valid, 1'b0);
        chk("bp_x_zero", (x == '0), 1'b1);
        chk("bp_s_ready", s_ready, 1'b1);
        $display("reset after 60 words");
        tick;

        // Full vector with random gaps after reset
        n = 0; cyc = 0;
        while (n < IN && cyc < 2000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data = WIDTH'(n * 7 + 3); s_last = (n == IN - 1);
            acc = s_valid && s_ready;
            tick;
            if (acc) n++;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("bp2_words", n, IN);
        chk("bp2_x_valid", x_valid, 1'b1);
        chk("bp2_err", err, 1'b0);
        mism = 0;
        for (int i = 0; i < IN; i++) if (xe(i) !== WIDTH'(i * 7 + 3)) mism++;
        chk("bp2_x_contents_mismatches", mism, 0);
        $display("post-reset vector: %0d words", n);
        x_ready = 1'b1;
        tick;
        x_ready = 1'b0;
        chk("bp2_rel_x_valid", x_valid, 1'b0);

`ifdef FC_IN_PINGPONG_EN
        // Three back-to-back vectors, no consumer
        n = 0; cyc = 0;
        while (cyc < 1000) begin
            if (!s_ready) break;
            s_valid = 1'b1;
            s_data = WIDTH'((n % IN) + (n / IN) * 50);
            s_last = ((n % IN) == IN - 1);
            tick;
            n++;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("pp_words_before_stall", n, 256);
        chk("pp_x_vec0", xe(5), 8'd5);
        x_ready = 1'b1;
        tick;
        x_ready = 1'b0;
        chk("pp_x_vec1", xe(5), 8'd55);
        chk("pp_x_valid", x_valid, 1'b1);
        chk("pp_s_ready_resume", s_ready, 1'b1);
        s_valid = 1'b1; s_data = 8'd100;
        tick;
        s_valid = 1'b0;
        chk("pp_x_vec1_held", xe(5), 8'd55);
        chk("pp_s_ready_still", s_ready, 1'b1);
        $display("ping-pong: %0d words before stall", n);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_in_buffer.md
# fc_in_buffer

Input-side collector for the fully-connected layer: accepts activations one word per cycle over a valid/ready stream and assembles them into the parallel `x[0:IN-1]` vector that the combinational FC layer (Booth multipliers, adder tree, ReLU) consumes. It holds the vector stable while the layer and its output register settle, then releases it through a vector-level handshake. The block sits directly upstream of each `fc*` layer instance.

## Interface
- `WIDTH`, 8, activation word width; matches the layer's `WIDTH`
- `IN`, 128, vector length; matches the layer's `IN`
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_data`  in  WIDTH  activation word
- `s_valid`  in  1  `s_data`/`s_last` valid
- `s_last`  in  1  marks the final word of a vector
- `s_ready`  out  1  buffer can accept a word
- `x`  out  WIDTH × [0:IN-1]  assembled vector; connects to the layer's `x`
- `x_valid`  out  1  `x` is a complete vector
- `x_ready`  in  1  consumer has captured `x`
- `err`  out  1  one-cycle pulse on a framing error

## Operation
- A word transfers when `s_valid & s_ready`; a vector transfers when `x_valid & x_ready`.
- A write index `wptr` (`$clog2(IN)` bits) selects the entry. Each accepted word writes entry `wptr`, then `wptr` increments.
- Single-bank FSM:
  - FILL: `s_ready=1`, `x_valid=0`.
  - On a transfer with `wptr==IN-1` or `s_last=1`, go to HOLD and set `wptr=0`.
  - HOLD: `s_ready=0`, `x_valid=1`.
  - On a vector transfer, go to FILL.
- Early last: `s_last=1` at index k<IN-1.
  - Entry k is written and entries k+1..IN-1 are cleared to 0 in the same cycle.
  - The vector completes; `err` pulses.
- Missing last: `wptr==IN-1` with `s_last=0`.
  - The vector completes; `err` pulses.
  - The next accepted word is index 0 of a new vector.
- In HOLD, the entries of `x` do not change until the vector handshake.
- Data is unsigned `WIDTH`-bit, stored unmodified; there is no arithmetic.

## Timing
- Reset values: all entries 0, `wptr=0`, FILL state, `x_valid=0`, `err=0`. `s_ready=0` while `rst=1`; `s_ready=1` in the first cycle after reset.
- Latency: `x_valid` rises in the cycle after the final word is accepted.
- After a vector transfer, `s_ready` rises in the next cycle (single bank).
- `err` is registered and is high for exactly the cycle after the offending word.
- `x_ready` while `x_valid=0` is ignored.
- Reset mid-vector discards the partial vector; the stream restarts at index 0.

## Configuration
- `FC_IN_PINGPONG_EN` defined:
  - Two banks with write bank select `wb`, read bank select `rb`, and a full count 0..2.
  - `s_ready = (count<2)`.
  - `x` shows bank `rb`; `x_valid = (count>0)`.
  - Vector completion sets the bank full and toggles `wb`. A vector transfer frees bank `rb` and toggles `rb`.
  - Completion and vector transfer in the same cycle leave `count` unchanged.
  - Filling of the next vector proceeds with no bubble while the previous vector is held.
- Undefined: the single-bank FSM above. Filling stalls during HOLD.

## Test plan
- Basic fill: stream words 1..128, `s_last` on the 128th, `x_ready=0` → `x_valid=1` one cycle after the last word; `x[i]=i+1`; `s_ready=0`; `x` stable over 10 cycles.
- Release: continuing from the basic-fill case, `x_ready=1` for one cycle → `x_valid=0` next cycle, `s_ready=1`, next word lands in `x[0]`.
- Early last: 5 words of 0xFF, `s_last` on the 5th → `x[0..4]=0xFF`, `x[5..127]=0`, `x_valid=1`, one `err` pulse.
- Missing last: 130 words, `s_last=0` throughout, `x_ready` tied 1 → vector completes at word 128 with `err` pulse; words 129–130 land in `x[0..1]` of the next vector.
- Backpressure / reset: toggle `s_valid` randomly; assert `rst` after 60 words → `x_valid=0`, all `x` entries 0; a full vector afterwards assembles correctly.
- `FC_IN_PINGPONG_EN`: stream 3 back-to-back vectors with `x_ready=0` → `s_ready` drops only after 256 words. Pulse `x_ready` once → vector 2 appears next cycle and filling of vector 3 resumes.
